// File: rtl/regfile_access_ctrl.sv
// Register-file front end: post-reset clear, write-port arbitration (wb over debug), read bypass.
// Read data is available 1 cycle after the address; debug writes stall while write-back holds the port.
module regfile_access_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_init_done,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_waddr,
  input  logic [DATA_W-1:0] i_wb_wdata,
  input  logic              i_dbg_valid,
  output logic              o_dbg_ready,
  input  logic [ADDR_W-1:0] i_dbg_waddr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic [ADDR_W-1:0] o_ram_raddr1,
  output logic [ADDR_W-1:0] o_ram_raddr2,
  input  logic [DATA_W-1:0] i_ram_rdata1,
  input  logic [DATA_W-1:0] i_ram_rdata2
);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam logic ST_RST  = INIT_CLEAR ? ST_INIT : ST_RUN;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              eff_we;
  logic [ADDR_W-1:0] eff_waddr;
  logic [DATA_W-1:0] eff_wdata;
  logic              dbg_ready;
  logic              wb_hit;

  logic              zero1_q, zero1_d, zero2_q, zero2_d;
  logic              byp1_q, byp1_d, byp2_q, byp2_d;
  logic [DATA_W-1:0] byp_data1_q, byp_data2_q;

  // A write-back to x0 is a no-op, so it leaves the port free for a waiting debug request.
  assign wb_hit = i_wb_we && (i_wb_waddr != '0);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    eff_we    = 1'b0;
    eff_waddr = clr_cnt_q;
    eff_wdata = '0;
    dbg_ready = 1'b0;
    if (state_q == ST_INIT) begin
      eff_we    = 1'b1;
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end else if (wb_hit) begin
      eff_we    = 1'b1;
      eff_waddr = i_wb_waddr;
      eff_wdata = i_wb_wdata;
    end else if (i_dbg_valid) begin
      dbg_ready = 1'b1;
      eff_we    = (i_dbg_waddr != '0);
      eff_waddr = i_dbg_waddr;
      eff_wdata = i_dbg_wdata;
    end
  end

  always_comb begin
    zero1_d = (i_raddr1 == '0);
    zero2_d = (i_raddr2 == '0);
    byp1_d  = eff_we && (eff_waddr == i_raddr1) && !zero1_d;
    byp2_d  = eff_we && (eff_waddr == i_raddr2) && !zero2_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      clr_cnt_q   <= '0;
      zero1_q     <= 1'b1;
      zero2_q     <= 1'b1;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp_data1_q <= '0;
      byp_data2_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      zero1_q     <= zero1_d;
      zero2_q     <= zero2_d;
      byp1_q      <= byp1_d;
      byp2_q      <= byp2_d;
      byp_data1_q <= eff_wdata;
      byp_data2_q <= eff_wdata;
    end
  end

  // The RAM returns pre-write data for a same-cycle read, hence the captured bypass copy.
  assign o_rdata1 = zero1_q ? '0 : (byp1_q ? byp_data1_q : i_ram_rdata1);
  assign o_rdata2 = zero2_q ? '0 : (byp2_q ? byp_data2_q : i_ram_rdata2);

  assign o_init_done  = (state_q == ST_RUN);
  assign o_dbg_ready  = dbg_ready;
  assign o_ram_we     = eff_we;
  assign o_ram_waddr  = eff_waddr;
  assign o_ram_wdata  = eff_wdata;
  assign o_ram_raddr1 = i_raddr1;
  assign o_ram_raddr2 = i_raddr2;

endmodule
